l2cache_2way: RTL

Parametrised two-way set-associative, write-back, write-allocate L2 cache with true-LRU replacement and hit/miss counters. It sits between the L1 caches/processor-side arbiter (30-bit word address, 32-bit data) and the main-memory controller (28-bit block address, 128-bit blocks of 4 words). It is a drop-in replacement for the direct-mapped L2 and has the same port set plus two statistics outputs.

---
 rtl/l2cache_pkg.sv | 22 ++
 rtl/l2cache_way.sv | 61 ++++++
 rtl/l2cache_2way.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/l2cache_pkg.sv
// Shared types and widths for the two-way L2 cache.
package l2cache_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 128;
  localparam int PADDR_W = 30;
  localparam int MADDR_W = 28;

  // Controller state: IDLE serves hits, WB writes a dirty victim back, FILL refills.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } state_e;

  // Picks word idx out of a 4-word block (word 0 in the low bits).
  function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                 input logic [1:0]         idx);
    return blk[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/l2cache_way.sv
// One way of the cache: valid/dirty/tag/data per set, combinational lookup,
// a single-word write port (hit writes) and a whole-block fill port.
module l2cache_way
  import l2cache_pkg::*;
#(
  parameter int SET_BITS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [SET_BITS-1:0]           set_i,
  input  logic [MADDR_W-SET_BITS-1:0]   tag_i,
  output logic                          hit_o,
  output logic                          valid_o,
  output logic                          dirty_o,
  output logic [MADDR_W-SET_BITS-1:0]   tag_o,
  output logic [BLOCK_W-1:0]            data_o,
  input  logic                          wr_en_i,
  input  logic [1:0]                    wr_word_i,
  input  logic [WORD_W-1:0]             wr_data_i,
  input  logic                          fill_en_i,
  input  logic [BLOCK_W-1:0]            fill_data_i
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = MADDR_W - SET_BITS;

  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [BLOCK_W-1:0] data_q [SETS];

  assign valid_o = valid_q[set_i];
  assign dirty_o = dirty_q[set_i];
  assign tag_o   = tag_q[set_i];
  assign data_o  = data_q[set_i];
  assign hit_o   = valid_q[set_i] && (tag_q[set_i] == tag_i);

  // Status bits: reset empties the way; a fill makes the line clean, a write dirties it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[set_i] <= 1'b1;
      dirty_q[set_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[set_i] <= 1'b1;
    end
  end

  // Tag and data storage; no reset needed since valid gates every use.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[set_i]  <= tag_i;
      data_q[set_i] <= fill_data_i;
    end else if (wr_en_i) begin
      data_q[set_i][wr_word_i*WORD_W +: WORD_W] <= wr_data_i;
    end
  end

endmodule

// File: rtl/l2cache_2way.sv
// Two-way set-associative write-back / write-allocate L2 with true LRU and
// saturating hit/miss statistics.
// Memory handshake: mem_read/mem_write are held high with a stable mem_addr
// (and mem_wdata) until mem_ready is seen high for exactly one cycle; that
// edge completes the request. mem_ready is ignored in IDLE.
module l2cache_2way
  import l2cache_pkg::*;
#(
  parameter int SET_BITS = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                proc_reset,
  input  logic                proc_read,
  input  logic                proc_write,
  input  logic [PADDR_W-1:0]  proc_addr,
  input  logic [WORD_W-1:0]   proc_wdata,
  output logic [WORD_W-1:0]   proc_rdata,
  output logic                proc_stall,
  output logic                mem_read,
  output logic                mem_write,
  output logic [MADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0]  mem_wdata,
  input  logic [BLOCK_W-1:0]  mem_rdata,
  input  logic                mem_ready,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = MADDR_W - SET_BITS;

  state_e state_q, state_d;
  logic               mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [MADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [SETS-1:0]    lru_q;
  logic               victim_q, fill_done_q;
  logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    tag_in;
  logic [1:0]          hit_w, valid_w, dirty_w, wr_en_w, fill_en_w;
  logic [TAG_W-1:0]    tag_w  [2];
  logic [BLOCK_W-1:0]  data_w [2];
  logic req, hit, acc_hit, miss_now, victim_now, victim_dirty, fill_go;

  assign set_idx = proc_addr[SET_BITS+1:2];
  assign tag_in  = proc_addr[PADDR_W-1:SET_BITS+2];

  for (genvar g = 0; g < 2; g++) begin : g_way
    l2cache_way #(.SET_BITS(SET_BITS)) u_way (
      .clk_i      (clk),
      .rst_i      (proc_reset),
      .set_i      (set_idx),
      .tag_i      (tag_in),
      .hit_o      (hit_w[g]),
      .valid_o    (valid_w[g]),
      .dirty_o    (dirty_w[g]),
      .tag_o      (tag_w[g]),
      .data_o     (data_w[g]),
      .wr_en_i    (wr_en_w[g]),
      .wr_word_i  (proc_addr[1:0]),
      .wr_data_i  (proc_wdata),
      .fill_en_i  (fill_en_w[g]),
      .fill_data_i(mem_rdata)
    );
  end

  assign req          = proc_read | proc_write;
  assign hit          = |hit_w;
  assign acc_hit      = (state_q == IDLE) && req && hit;
  assign miss_now     = (state_q == IDLE) && req && !hit;
  // Prefer an empty way (way 0 first); otherwise evict the LRU way.
  assign victim_now   = !valid_w[0] ? 1'b0 : (!valid_w[1] ? 1'b1 : lru_q[set_idx]);
  assign victim_dirty = valid_w[victim_now] & dirty_w[victim_now];
  assign fill_go      = (state_q == FILL) && mem_ready;
  assign wr_en_w      = (acc_hit && proc_write) ? hit_w : 2'b00;
  assign fill_en_w    = fill_go ? (victim_q ? 2'b10 : 2'b01) : 2'b00;

  assign proc_stall = req & ~hit;
  assign proc_rdata = (proc_read && hit) ? word_sel(hit_w[1] ? data_w[1] : data_w[0], proc_addr[1:0])
                                         : '0;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  // State register plus the registered memory request outputs.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state: a miss leaves IDLE, each mem_ready advances one phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_now) state_d = victim_dirty ? WB : FILL;
      WB:      if (mem_ready) state_d = FILL;
      FILL:    if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the memory request registers for each transition.
  always_comb begin
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (miss_now) begin
          if (victim_dirty) begin
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_w[victim_now], set_idx};
            mem_wdata_d = data_w[victim_now];
          end else begin
            mem_read_d  = 1'b1;
            mem_addr_d  = proc_addr[PADDR_W-1:2];
          end
        end
      end
      WB: begin
        if (mem_ready) begin
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = proc_addr[PADDR_W-1:2];
        end
      end
      FILL:    if (mem_ready) mem_read_d = 1'b0;
      default: ;
    endcase
  end

  // Victim latch, LRU bits and the post-fill marker that keeps the refill
  // completion out of the hit statistics.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      victim_q    <= 1'b0;
      lru_q       <= '0;
      fill_done_q <= 1'b0;
    end else begin
      if (miss_now) victim_q <= victim_now;
      if (acc_hit) lru_q[set_idx] <= ~hit_w[1];
      fill_done_q <= fill_go;
    end
  end

  // Saturating hit/miss counters.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (acc_hit && !fill_done_q && (hit_cnt_q != {CNT_W{1'b1}}))
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (miss_now && (miss_cnt_q != {CNT_W{1'b1}}))
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

endmodule
